calc_engine: RTL and testbench



---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_muldiv.sv | 77 +++++++
 rtl/calc_engine.sv | 144 ++++++++++++++
 tb/tb_calc_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings and sizing helpers for the calculator core.
// Pure definitions: no latency, no backpressure.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_SHL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_WAIT_A = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } stage_t;

    function automatic int hist_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/calc_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: WIDTH iterations (first at the start edge), done pulses for one cycle after the last.
// No backpressure: start is only issued while idle, clear aborts immediately.
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    // hi/lo hold {product} for MUL and {remainder, quotient/dividend} for DIV
    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             is_mul_q, run_q;
    logic [CW-1:0]    cnt_q, cnt_nx;

    logic [WIDTH-1:0] hi_src, lo_src, m_src, hi_nx, lo_nx;
    logic             mul_src;
    logic [WIDTH:0]   sum, shifted, diff;

    always_comb begin
        mul_src = start ? (op == OP_MUL) : is_mul_q;
        m_src   = start ? ((op == OP_MUL) ? a : b) : m_q;
        hi_src  = start ? '0 : hi_q;
        lo_src  = start ? ((op == OP_MUL) ? b : a) : lo_q;
        sum     = {1'b0, hi_src} + (lo_src[0] ? {1'b0, m_src} : '0);
        shifted = {hi_src, lo_src[WIDTH-1]};
        diff    = shifted - {1'b0, m_src};
        hi_nx   = shifted[WIDTH-1:0];
        lo_nx   = {lo_src[WIDTH-2:0], 1'b0};
        if (mul_src) begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo_src[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_nx = diff[WIDTH-1:0];
            lo_nx = {lo_src[WIDTH-2:0], 1'b1};
        end
        cnt_nx = start ? CW'(1) : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            is_mul_q <= 1'b0;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || run_q) begin
                hi_q     <= hi_nx;
                lo_q     <= lo_nx;
                m_q      <= m_src;
                is_mul_q <= mul_src;
                cnt_q    <= cnt_nx;
                run_q    <= (cnt_nx != CW'(WIDTH));
                done     <= (cnt_nx == CW'(WIDTH));
            end
        end
    end

    assign result = lo_q;
    assign ovf    = is_mul_q & (|hi_q);

endmodule

// File: rtl/calc_engine.sv
// Calculator core: operand entry FSM, single-cycle ALU, iterative mul/div, result history.
// Latency: 1 cycle after B capture for single-cycle ops, WIDTH cycles for MUL/DIV.
// No backpressure: next rising edges outside WAIT_A/WAIT_B/DONE are ignored.
module calc_engine
    import calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          next,
    input  logic [2:0]                    MS,
    input  logic [WIDTH-1:0]              Din,
    input  logic [hist_idx_w(DEPTH)-1:0]  hist_idx,
    output logic [WIDTH-1:0]              result,
    output logic                          done,
    output logic                          busy,
    output logic                          carry,
    output logic                          err,
    output logic [1:0]                    stage,
    output logic [WIDTH-1:0]              hist_data,
    output logic [hist_idx_w(DEPTH):0]    hist_count
);

    localparam int IW = hist_idx_w(DEPTH);
    localparam int SW = $clog2(WIDTH);

    stage_t           st_q;
    logic             next_q, nxt_p;
    logic [WIDTH-1:0] a_q, b_q;
    op_t              op_q, ms_op;
    logic [WIDTH-1:0] hist [DEPTH];

    logic             md_start, md_done, md_ovf;
    logic [WIDTH-1:0] md_res;

    logic             iterative, finish;
    logic [WIDTH-1:0] res_nx;
    logic             carry_nx, err_nx;

    assign nxt_p = next & ~next_q;
    assign ms_op = op_t'(MS);

    // A zero divisor takes the single-cycle path, so it never starts the divider
    assign md_start = (st_q == ST_WAIT_B) && nxt_p &&
                      ((ms_op == OP_MUL) || ((ms_op == OP_DIV) && (Din != '0)));

    calc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .clear  (clear),
        .start  (md_start),
        .op     (ms_op),
        .a      (a_q),
        .b      (Din),
        .done   (md_done),
        .result (md_res),
        .ovf    (md_ovf)
    );

    assign iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    assign finish    = iterative ? md_done : 1'b1;

    always_comb begin
        res_nx   = '0;
        carry_nx = 1'b0;
        err_nx   = 1'b0;
        case (op_q)
            OP_ADD: {carry_nx, res_nx} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                res_nx   = a_q - b_q;
                carry_nx = (a_q < b_q);
            end
            OP_AND: res_nx = a_q & b_q;
            OP_OR:  res_nx = a_q | b_q;
            OP_XOR: res_nx = a_q ^ b_q;
            OP_MUL: begin
                res_nx   = md_res;
                carry_nx = md_ovf;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_nx = '1;
                    err_nx = 1'b1;
                end else begin
                    res_nx = md_res;
                end
            end
            OP_SHL: res_nx = a_q << b_q[SW-1:0];
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            next_q     <= 1'b0;
            st_q       <= ST_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            result     <= '0;
            carry      <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            hist_count <= '0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            next_q <= next;
            case (st_q)
                ST_WAIT_A: if (nxt_p) begin
                    a_q  <= Din;
                    st_q <= ST_WAIT_B;
                end
                ST_WAIT_B: if (nxt_p) begin
                    b_q  <= Din;
                    op_q <= ms_op;
                    st_q <= ST_EXEC;
                    busy <= 1'b1;
                end
                ST_EXEC: if (finish) begin
                    result <= res_nx;
                    carry  <= carry_nx;
                    err    <= err_nx;
                    st_q   <= ST_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
                    hist[0] <= res_nx;
                    if (hist_count != (IW+1)'(DEPTH)) hist_count <= hist_count + 1'b1;
                end
                ST_DONE: if (nxt_p) begin
                    st_q <= ST_WAIT_A;
                    done <= 1'b0;
                end
                default: st_q <= ST_WAIT_A;
            endcase
        end
    end

    assign stage     = st_q;
    assign hist_data = ({1'b0, hist_idx} < hist_count) ? hist[hist_idx] : '0;

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine (WIDTH=16; DEPTH=4 main instance, DEPTH=8 side instance).
module tb_calc_engine;

    logic        clk = 1'b0;
    logic        clear, next;
    logic [2:0]  MS;
    logic [15:0] Din;
    logic [1:0]  hist_idx;
    logic [2:0]  hist_idx8;

    logic [15:0] result, hist_data, result8, hist_data8;
    logic        done, busy, carry, err, done8, busy8, carry8, err8;
    logic [1:0]  stage, stage8;
    logic [2:0]  hist_count;
    logic [3:0]  hist_count8;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] hq[$];
    logic [15:0] got_res;
    logic        got_c, got_e;
    int          got_lat, got_busy;

    always #5 clk = ~clk;

    calc_engine #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .clear(clear), .next(next), .MS(MS), .Din(Din), .hist_idx(hist_idx),
        .result(result), .done(done), .busy(busy), .carry(carry), .err(err),
        .stage(stage), .hist_data(hist_data), .hist_count(hist_count)
    );

    calc_engine #(.WIDTH(16), .DEPTH(8)) dut8 (
        .clk(clk), .clear(clear), .next(next), .MS(MS), .Din(Din), .hist_idx(hist_idx8),
        .result(result8), .done(done8), .busy(busy8), .carry(carry8), .err(err8),
        .stage(stage8), .hist_data(hist_data8), .hist_count(hist_count8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ms;
        logic [15:0] r;
        logic        c;
        logic        e;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] d, input logic [2:0] m);
        Din  = d;
        MS   = m;
        next = 1'b1;
        step();
        next = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        got_lat  = 0;
        got_busy = 0;
        while (!done && got_lat < 100) begin
            if (busy) got_busy++;
            if (toggle) next = ~next;
            step();
            got_lat++;
        end
        next    = 1'b0;
        got_res = result;
        got_c   = carry;
        got_e   = err;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m);
        press(a, 3'b000);
        step();
        press(b, m);
        wait_done(1'b0);
    endtask

    task automatic leave_done();
        press(16'h0000, 3'b000);
        step();
    endtask

    task automatic push_model(input logic [15:0] r);
        hq.push_front(r);
        if (hq.size() > 4) void'(hq.pop_back());
    endtask

    task automatic check_hist(input string nm);
        logic [15:0] exp;
        chk({nm, " hist_count"}, 32'(hist_count), 32'(hq.size()));
        for (int i = 0; i < 4; i++) begin
            hist_idx = 2'(i);
            #1;
            exp = (i < hq.size()) ? hq[i] : 16'h0000;
            chk($sformatf("%s hist[%0d]", nm, i), 32'(hist_data), 32'(exp));
        end
        hist_idx = 2'd0;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        next  = 1'b0;
        step();
        clear = 1'b0;
        hq.delete();
    endtask

    // Reference computed directly from the arithmetic definition of each op
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                                  output logic [15:0] r, output logic c, output logic e,
                                  output int lat);
        logic [16:0] s;
        logic [31:0] p;
        c = 1'b0; e = 1'b0; lat = 1; r = 16'h0;
        case (m)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; c = (p[31:16] != 0); lat = 16; end
            3'd6: begin
                if (b == 0) begin r = 16'hFFFF; e = 1'b1; end
                else begin r = a / b; lat = 16; end
            end
            default: r = a << b[3:0];
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, er;
        logic [2:0]  rm;
        logic        ec, ee;
        int          el;

        tbl[0]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b0, 1};
        tbl[1]  = '{16'd300,  16'd300,  3'd5, 16'h5F90, 1'b1, 1'b0, 16};
        tbl[2]  = '{16'd100,  16'd7,    3'd6, 16'h000E, 1'b0, 1'b0, 16};
        tbl[3]  = '{16'd100,  16'd0,    3'd6, 16'hFFFF, 1'b0, 1'b1, 1};
        tbl[4]  = '{16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b1, 1'b0, 1};
        tbl[5]  = '{16'hF0F0, 16'h3C3C, 3'd2, 16'h3030, 1'b0, 1'b0, 1};
        tbl[6]  = '{16'hF0F0, 16'h3C3C, 3'd3, 16'hFCFC, 1'b0, 1'b0, 1};
        tbl[7]  = '{16'hF0F0, 16'h3C3C, 3'd4, 16'hCCCC, 1'b0, 1'b0, 1};
        tbl[8]  = '{16'h0003, 16'h0013, 3'd7, 16'h0018, 1'b0, 1'b0, 1};
        tbl[9]  = '{16'h8001, 16'h0001, 3'd7, 16'h0002, 1'b0, 1'b0, 1};
        tbl[10] = '{16'h00FF, 16'h0101, 3'd5, 16'hFFFF, 1'b0, 1'b0, 16};
        tbl[11] = '{16'hFFFF, 16'h0001, 3'd6, 16'hFFFF, 1'b0, 1'b0, 16};
        tbl[12] = '{16'h1234, 16'h1111, 3'd0, 16'h2345, 1'b0, 1'b0, 1};

        clear = 1'b1; next = 1'b0; MS = 3'd0; Din = 16'h0; hist_idx = 2'd0; hist_idx8 = 3'd0;
        step();
        step();
        clear = 1'b0;

        chk("reset result", 32'(result), 0);
        chk("reset done", 32'(done), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset carry", 32'(carry), 0);
        chk("reset err", 32'(err), 0);
        chk("reset stage", 32'(stage), 0);
        chk("reset hist_count", 32'(hist_count), 0);
        chk("reset hist_data", 32'(hist_data), 0);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].ms);
            push_model(tbl[i].r);
            chk($sformatf("vec%0d result", i), 32'(got_res), 32'(tbl[i].r));
            chk($sformatf("vec%0d carry", i), 32'(got_c), 32'(tbl[i].c));
            chk($sformatf("vec%0d err", i), 32'(got_e), 32'(tbl[i].e));
            chk($sformatf("vec%0d latency", i), got_lat, tbl[i].lat);
            chk($sformatf("vec%0d busy cycles", i), got_busy, tbl[i].lat);
            chk($sformatf("vec%0d hist_data", i), 32'(hist_data), 32'(tbl[i].r));
            leave_done();
            chk($sformatf("vec%0d stage after", i), 32'(stage), 0);
        end
        check_hist("directed");

        // next held high for 10 cycles captures A exactly once
        Din = 16'h1234; MS = 3'd0; next = 1'b1;
        step();
        Din = 16'h9999;
        repeat (9) step();
        chk("held next stage", 32'(stage), 1);
        next = 1'b0;
        step();
        chk("held next still WAIT_B", 32'(stage), 1);
        press(16'h0001, 3'd0);
        wait_done(1'b0);
        push_model(16'h1235);
        chk("held next result", 32'(got_res), 32'h1235);
        leave_done();

        // next pulses during EXEC are ignored
        press(16'd300, 3'd0);
        step();
        press(16'd300, 3'd5);
        wait_done(1'b1);
        push_model(16'h5F90);
        chk("pulse exec latency", got_lat, 16);
        chk("pulse exec result", 32'(got_res), 32'h5F90);
        step();
        chk("pulse exec stays DONE", 32'(stage), 3);
        leave_done();
        check_hist("after pulses");

        // History fill and DEPTH=8 empty-slot read
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            run_op(16'(i * 256), 16'(i), 3'd0);
            push_model(16'(i * 257));
            leave_done();
            if (i == 2) begin
                chk("depth8 hist_count", 32'(hist_count8), 2);
                hist_idx8 = 3'd5;
                #1;
                chk("depth8 hist[5]", 32'(hist_data8), 0);
                hist_idx8 = 3'd1;
                #1;
                chk("depth8 hist[1]", 32'(hist_data8), 32'h0101);
                hist_idx = 2'd2;
                #1;
                chk("depth4 hist[2] partial", 32'(hist_data), 0);
                hist_idx = 2'd0;
            end
        end
        check_hist("five ops");

        // Randomised ops against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rm = 3'($urandom_range(0, 7));
            model(ra, rb, rm, er, ec, ee, el);
            run_op(ra, rb, rm);
            push_model(er);
            chk($sformatf("rand%0d op%0d result", n, rm), 32'(got_res), 32'(er));
            chk($sformatf("rand%0d carry", n), 32'(got_c), 32'(ec));
            chk($sformatf("rand%0d err", n), 32'(got_e), 32'(ee));
            chk($sformatf("rand%0d latency", n), got_lat, el);
            leave_done();
            check_hist($sformatf("rand%0d", n));
        end

        // clear in the middle of a MUL
        press(16'd300, 3'd0);
        step();
        press(16'd300, 3'd5);
        repeat (7) step();
        chk("mid-mul busy", 32'(busy), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        hq.delete();
        chk("clear stage", 32'(stage), 0);
        chk("clear result", 32'(result), 0);
        chk("clear busy", 32'(busy), 0);
        chk("clear done", 32'(done), 0);
        chk("clear carry", 32'(carry), 0);
        chk("clear err", 32'(err), 0);
        check_hist("after clear");
        repeat (20) step();
        chk("clear no late done", 32'(done), 0);
        chk("clear stage stays", 32'(stage), 0);

        // clear together with a rising next in WAIT_A
        Din = 16'h0055; clear = 1'b1; next = 1'b1;
        step();
        clear = 1'b0; next = 1'b0;
        step();
        chk("clear+next stage", 32'(stage), 0);
        run_op(16'h0002, 16'h0003, 3'd0);
        push_model(16'h0005);
        chk("clear+next result", 32'(got_res), 5);
        leave_done();
        check_hist("clear+next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
